// File: rtl/cpu_reset_sequencer_pkg.sv
// Shared types and defaults for the CPU reset/run-control sequencer.
// FSM state encoding, default parameter values and the program-counter width.
package cpu_rstseq_pkg;

    localparam int PC_W = 32;

    localparam int DEF_NUM_CH      = 3;
    localparam int DEF_HOLD_CYCLES = 10;
    localparam int DEF_STAGE_GAP   = 2;
    localparam int DEF_STALL_LIMIT = 16;
    localparam int DEF_MAX_CYCLES  = 100000;
    localparam int DEF_CNT_W       = 32;

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_STAGE = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cpu_reset_sequencer_rst_sync2.sv
// Two-flop reset synchroniser: asserts asynchronously with arst_n, releases
// synchronously two clock edges after arst_n rises.
module rst_sync2 (
    input  logic clk,
    input  logic arst_n,
    output logic srst_n
);

    logic meta;

    // Shift ones through the chain once the external reset lets go.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta   <= 1'b0;
            srst_n <= 1'b0;
        end else begin
            meta   <= 1'b1;
            srst_n <= meta;
        end
    end

endmodule

// File: rtl/cpu_reset_sequencer.sv
// Reset and run-control harness for the MIPS core and its memories.
// Holds all reset channels after the synchronised release, frees them one by
// one (channel 0 first), then counts run cycles and watches the PC for a halt
// or a cycle timeout. soft_restart re-runs the whole sequence.
// Optional build macro CPU_RSTSEQ_SNAPSHOT_EN adds halt_pc / halt_cycle
// outputs that record where and when the core halted.
module cpu_reset_sequencer
    import cpu_rstseq_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGE_GAP   = DEF_STAGE_GAP,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              soft_restart,
    input  logic [PC_W-1:0]   pc,
    input  logic              pc_valid,
    output logic [NUM_CH-1:0] rst_out,
    output logic              running,
    output logic              halted,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_cnt
`ifdef CPU_RSTSEQ_SNAPSHOT_EN
    ,
    output logic [PC_W-1:0]   halt_pc,
    output logic [CNT_W-1:0]  halt_cycle
`endif
);

    localparam logic [31:0]      HOLD_LAST  = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0]      GAP_LAST   = 32'(STAGE_GAP - 1);
    localparam logic [31:0]      STALL_LAST = 32'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_CYCLES - 1);
    localparam bit               TO_EN      = (MAX_CYCLES != 0);

    logic            srst_n;
    state_t          state;
    logic [31:0]     cnt;
    logic [31:0]     stall_cnt;
    logic [PC_W-1:0] last_pc;

    logic            pc_same;
    logic [31:0]     stall_nxt;
    logic            halt_det;
    logic            to_det;

    rst_sync2 u_sync (
        .clk    (clk),
        .arst_n (reset),
        .srst_n (srst_n)
    );

    // Next stall count and the halt/timeout detections seen while running.
    always_comb begin
        pc_same   = pc_valid && (pc == last_pc);
        stall_nxt = stall_cnt;
        if (pc_valid) begin
            stall_nxt = pc_same ? (stall_cnt + 32'd1) : 32'd0;
        end
        halt_det = (stall_nxt == STALL_LAST);
        to_det   = TO_EN && (cycle_cnt == MAX_LAST);
    end

    // Sequencer FSM with registered outputs. A restart behaves like the
    // synchronised release edge: hold count starts from zero on that edge.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state      <= S_HOLD;
            cnt        <= '0;
            stall_cnt  <= '0;
            last_pc    <= '0;
            rst_out    <= '1;
            running    <= 1'b0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
            cycle_cnt  <= '0;
`ifdef CPU_RSTSEQ_SNAPSHOT_EN
            halt_pc    <= '0;
            halt_cycle <= '0;
`endif
        end else if (soft_restart) begin
            state      <= S_HOLD;
            cnt        <= '0;
            stall_cnt  <= '0;
            last_pc    <= '0;
            rst_out    <= '1;
            running    <= 1'b0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
            cycle_cnt  <= '0;
`ifdef CPU_RSTSEQ_SNAPSHOT_EN
            halt_pc    <= '0;
            halt_cycle <= '0;
`endif
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state   <= S_STAGE;
                        cnt     <= '0;
                        // Channel 0 is freed on entry; with no gap, all go at once.
                        rst_out <= (STAGE_GAP == 0) ? '0 : (rst_out << 1);
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_STAGE: begin
                    if (rst_out == '0) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end else if (cnt == GAP_LAST) begin
                        rst_out <= rst_out << 1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_RUN: begin
                    stall_cnt <= stall_nxt;
                    if (pc_valid && !pc_same) begin
                        last_pc <= pc;
                    end
                    if (halt_det || to_det) begin
                        state   <= S_DONE;
                        running <= 1'b0;
                        halted  <= halt_det;
                        timeout <= to_det;
`ifdef CPU_RSTSEQ_SNAPSHOT_EN
                        if (halt_det) begin
                            halt_pc    <= last_pc;
                            halt_cycle <= cycle_cnt;
                        end
`endif
                    end else if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // S_DONE: everything frozen until restart or reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Directed bench for cpu_reset_sequencer: staged release with and without a
// gap, halt detection, timeout, soft restart and asynchronous abort.
module tb_cpu_reset_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        soft_restart;
    logic [31:0] pc_a;
    logic        pc_valid_a;
    logic [31:0] pc_c;
    logic        sr_c;

    logic [2:0]  rst_a, rst_b, rst_c;
    logic        run_a, run_b, run_c;
    logic        hlt_a, hlt_b, hlt_c;
    logic        to_a, to_b, to_c;
    logic [31:0] cc_a, cc_b, cc_c;
`ifdef CPU_RSTSEQ_SNAPSHOT_EN
    logic [31:0] hpc_a, hpc_b, hpc_c;
    logic [31:0] hcy_a, hcy_b, hcy_c;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Default parameters: 3 channels, hold 10, gap 2.
    cpu_reset_sequencer #(.NUM_CH(3), .HOLD_CYCLES(10), .STAGE_GAP(2),
                          .STALL_LIMIT(16), .MAX_CYCLES(100000), .CNT_W(32)) u_a (
        .clk(clk), .reset(reset), .soft_restart(soft_restart),
        .pc(pc_a), .pc_valid(pc_valid_a),
        .rst_out(rst_a), .running(run_a), .halted(hlt_a), .timeout(to_a),
        .cycle_cnt(cc_a)
`ifdef CPU_RSTSEQ_SNAPSHOT_EN
        , .halt_pc(hpc_a), .halt_cycle(hcy_a)
`endif
    );

    // No gap between channel releases.
    cpu_reset_sequencer #(.NUM_CH(3), .HOLD_CYCLES(10), .STAGE_GAP(0),
                          .STALL_LIMIT(16), .MAX_CYCLES(100000), .CNT_W(32)) u_b (
        .clk(clk), .reset(reset), .soft_restart(soft_restart),
        .pc(pc_a), .pc_valid(pc_valid_a),
        .rst_out(rst_b), .running(run_b), .halted(hlt_b), .timeout(to_b),
        .cycle_cnt(cc_b)
`ifdef CPU_RSTSEQ_SNAPSHOT_EN
        , .halt_pc(hpc_b), .halt_cycle(hcy_b)
`endif
    );

    // Short timeout with an always-advancing PC.
    cpu_reset_sequencer #(.NUM_CH(3), .HOLD_CYCLES(10), .STAGE_GAP(2),
                          .STALL_LIMIT(16), .MAX_CYCLES(50), .CNT_W(32)) u_c (
        .clk(clk), .reset(reset), .soft_restart(sr_c),
        .pc(pc_c), .pc_valid(1'b1),
        .rst_out(rst_c), .running(run_c), .halted(hlt_c), .timeout(to_c),
        .cycle_cnt(cc_c)
`ifdef CPU_RSTSEQ_SNAPSHOT_EN
        , .halt_pc(hpc_c), .halt_cycle(hcy_c)
`endif
    );

    always @(negedge clk) pc_c = pc_c + 32'd4;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset        = 1'b0;
        soft_restart = 1'b0;
        sr_c         = 1'b0;
        pc_a         = 32'h0;
        pc_valid_a   = 1'b0;
        pc_c         = 32'h100;

        // Reset values while reset is held low.
        step(3);
        check_eq("rst_rst_out", rst_a, 3'b111);
        check_eq("rst_running", run_a, 1'b0);
        check_eq("rst_halted", hlt_a, 1'b0);
        check_eq("rst_timeout", to_a, 1'b0);
        check_eq("rst_cycle_cnt", cc_a, 0);

        // Release at cycle 0; edge numbers below count from here.
        reset = 1'b1;
        step(11);
        check_eq("e11_a_rst", rst_a, 3'b111);
        check_eq("e11_b_rst", rst_b, 3'b111);
        step(1);
        check_eq("e12_a_rst", rst_a, 3'b110);
        check_eq("e12_b_rst_nogap", rst_b, 3'b000);
        step(1);
        check_eq("e13_a_rst", rst_a, 3'b110);
        check_eq("e13_b_running", run_b, 1'b1);
        step(1);
        check_eq("e14_a_rst", rst_a, 3'b100);
        step(2);
        check_eq("e16_a_rst", rst_a, 3'b000);
        check_eq("e16_a_running", run_a, 1'b0);
        step(1);
        check_eq("e17_a_running", run_a, 1'b1);
        check_eq("e17_a_cycle_cnt", cc_a, 0);

        // Hold pc for 16 cycles: halt on the 16th.
        pc_a       = 32'h0000_3010;
        pc_valid_a = 1'b1;
        step(15);
        check_eq("stall15_halted", hlt_a, 1'b0);
        check_eq("stall15_cnt", cc_a, 15);
        step(1);
        check_eq("halt_halted", hlt_a, 1'b1);
        check_eq("halt_running", run_a, 1'b0);
        check_eq("halt_timeout", to_a, 1'b0);
        check_eq("halt_cnt", cc_a, 15);
`ifdef CPU_RSTSEQ_SNAPSHOT_EN
        check_eq("halt_pc", hpc_a, 32'h0000_3010);
        check_eq("halt_cycle", hcy_a, 15);
`endif
        step(3);
        check_eq("halt_cnt_frozen", cc_a, 15);
        check_eq("halt_sticky", hlt_a, 1'b1);
        check_eq("halt_rst_out", rst_a, 3'b000);

        // MAX_CYCLES = 50 timeout: edge 66 has cycle_cnt 49, edge 67 flags.
        step(30);
        check_eq("to_pre_cnt", cc_c, 49);
        check_eq("to_pre_flag", to_c, 1'b0);
        check_eq("to_pre_running", run_c, 1'b1);
        step(1);
        check_eq("to_flag", to_c, 1'b1);
        check_eq("to_halted", hlt_c, 1'b0);
        check_eq("to_cnt", cc_c, 49);
        check_eq("to_running", run_c, 1'b0);
        step(2);
        check_eq("to_cnt_frozen", cc_c, 49);

        // Soft restart from S_DONE.
        soft_restart = 1'b1;
        step(1);
        soft_restart = 1'b0;
        check_eq("sr_rst_out", rst_a, 3'b111);
        check_eq("sr_halted", hlt_a, 1'b0);
        check_eq("sr_cnt", cc_a, 0);
        step(9);
        check_eq("sr_p9_rst", rst_a, 3'b111);
        step(1);
        check_eq("sr_p10_rst", rst_a, 3'b110);
        step(2);
        check_eq("sr_p12_rst", rst_a, 3'b100);
        step(2);
        check_eq("sr_p14_rst", rst_a, 3'b000);
        step(1);
        check_eq("sr_p15_running", run_a, 1'b1);

        // Restart again, then drop reset while rst_out = 110.
        soft_restart = 1'b1;
        step(1);
        soft_restart = 1'b0;
        step(10);
        check_eq("abort_pre_rst", rst_a, 3'b110);
        reset = 1'b0;
        #1;
        check_eq("abort_async_rst", rst_a, 3'b111);
        check_eq("abort_c_timeout", to_c, 1'b0);
        check_eq("abort_c_cnt", cc_c, 0);
        step(2);
        reset = 1'b1;
        step(11);
        check_eq("rerun_e11_rst", rst_a, 3'b111);
        step(1);
        check_eq("rerun_e12_rst", rst_a, 3'b110);

        // Restart during hold restarts the hold count.
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(5);
        soft_restart = 1'b1;
        step(1);
        soft_restart = 1'b0;
        step(9);
        check_eq("holdsr_p9_rst", rst_a, 3'b111);
        step(1);
        check_eq("holdsr_p10_rst", rst_a, 3'b110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
